// File: rtl/icache_if.sv
// icache_if: fetch-side (imem*) and fill-side (iREN/iaddr/iwait/iload) signals of the instruction cache.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  modport slave (input imemREN, imemaddr, iwait, iload, flush, output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iwait, iload, flush, input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with single-word fills.
// Define ICACHE_FLUSH_EN to make the flush input invalidate all frames.
module icache #(
  parameter int SETS = 16
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, next_state;
  logic [SETS-1:0] valid, valid_next;
  logic [TW-1:0] tags [SETS];
  logic [31:0] data [SETS];
  logic [31:0] fill_addr;
  logic [IW-1:0] idx, fill_idx;
  logic hit, miss, fill_done, flush_idle, flush_all;
  logic unused_ok;
  assign idx = bus.imemaddr[IW+1:2];
  assign fill_idx = fill_addr[IW+1:2];
  assign fill_done = state == FETCH && !bus.iwait;
`ifdef ICACHE_FLUSH_EN
  logic pend;
  assign flush_idle = state == IDLE && bus.flush;
  // a flush seen during a fill is deferred so the in-flight word never lands as valid
  assign flush_all = flush_idle || (fill_done && (pend || bus.flush));
  assign unused_ok = ^{bus.imemaddr[1:0], fill_addr[1:0]};
  always_ff @(posedge CLK)
    if (!nRST) pend <= 1'b0;
    else pend <= fill_done ? 1'b0 : pend || (state == FETCH && bus.flush);
`else
  assign flush_idle = 1'b0;
  assign flush_all = 1'b0;
  assign unused_ok = ^{bus.imemaddr[1:0], fill_addr[1:0], bus.flush};
`endif
  assign hit = state == IDLE && bus.imemREN && valid[idx] && tags[idx] == bus.imemaddr[31:IW+2] && !flush_idle;
  assign miss = state == IDLE && bus.imemREN && !hit;
  always_comb begin
    next_state = state == IDLE ? (miss ? FETCH : IDLE) : (bus.iwait ? FETCH : IDLE);
    bus.ihit = hit;
    bus.imemload = hit ? data[idx] : '0;
    bus.iREN = state == FETCH;
    bus.iaddr = state == FETCH ? fill_addr : '0;
    valid_next = valid;
    if (fill_done) valid_next[fill_idx] = 1'b1;
    if (flush_all) valid_next = '0;
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
      fill_addr <= '0;
    end else begin
      state <= next_state;
      valid <= valid_next;
      if (miss) fill_addr <= {bus.imemaddr[31:2], 2'b00};
    end
  always_ff @(posedge CLK)
    if (nRST && fill_done) begin
      tags[fill_idx] <= fill_addr[31:IW+2];
      data[fill_idx] <= bus.iload;
    end
endmodule
